// File: rtl/state_update_driver.sv
// ----------------------------------------------------------------------------
// state_update_driver
//   Clocked sequencer that drives a level-sensitive state-update latch.
//   It issues state codes S0..S3 in order. Each code is surrounded by
//   setup, pulse and hold windows on the EN strobe. The latch's Zip output
//   is captured in the first hold cycle and compared with the expected
//   decode of the issued code.
//
//   Optional feature: define STATE_UPDATE_ERRCNT_EN to enable a saturating
//   mismatch counter on err_cnt. Without it, err_cnt is tied to zero.
// ----------------------------------------------------------------------------
module state_update_driver #(
  parameter int SETUP_CYC = 1,  // cycles state is stable with en=0 before en rises
  parameter int PULSE_CYC = 2,  // cycles en is held high
  parameter int HOLD_CYC  = 1   // cycles state is held with en=0 after en falls
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       step,
  input  logic [1:0] zip_in,
  output logic [1:0] current_state,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic [1:0] zip_cap,
  output logic       mismatch,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // The phase counter loads (length - 1) and counts down to zero, so it
  // only needs to hold values up to the longest phase minus one.
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_seq_idx;
  logic [1:0]       r_cur_state;
  logic             r_en;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_zip_cap;
  logic             r_mismatch;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_phase_end;
  logic             w_start;
  logic             w_hold_first;
  logic             w_hold_last;
  logic [1:0]       w_seq_inc;
  logic [1:0]       w_expected;
  logic             w_zip_bad;

  assign w_phase_end  = (r_cnt == '0);
  assign w_start      = (r_state == ST_IDLE) && (go || step);
  assign w_hold_first = (r_state == ST_HOLD) && (r_cnt == HOLD_LD);
  assign w_hold_last  = (r_state == ST_HOLD) && w_phase_end;
  assign w_seq_inc    = r_seq_idx + 2'd1;
  // Only S1 decodes to a non-zero Zip; every other code decodes to 00.
  assign w_expected   = (r_cur_state == 2'b01) ? 2'b11 : 2'b00;
  assign w_zip_bad    = (zip_in != w_expected);

  // Next-state and phase-counter logic for the IDLE/SETUP/PULSE/HOLD sequence.
  // NOTE: every always_comb output gets a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_phase_end ? r_cnt : r_cnt - CNT_W'(1);
    case (r_state)
      ST_IDLE: begin
        if (go || step) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (w_phase_end) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (w_phase_end) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (w_phase_end) begin
          if (go) begin
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = SETUP_LD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Sequencer registers. en and busy are registered from the next state, so
  // the latch enable comes straight from a flop and cannot glitch.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_seq_idx   <= 2'd0;
      r_cur_state <= 2'd0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= (w_state_nxt == ST_PULSE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_hold_last;
      if (w_hold_last) begin
        r_seq_idx <= w_seq_inc;
      end
      // The state code only moves on entry to SETUP, never during PULSE/HOLD.
      if (w_start) begin
        r_cur_state <= r_seq_idx;
      end else if (w_hold_last && go) begin
        r_cur_state <= w_seq_inc;
      end
    end
  end

  // Capture the latch output in the first HOLD cycle and flag a wrong decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zip_cap  <= 2'b00;
      r_mismatch <= 1'b0;
    end else if (w_hold_first) begin
      r_zip_cap  <= zip_in;
      r_mismatch <= w_zip_bad;
    end
  end

`ifdef STATE_UPDATE_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of captures that disagreed with the expected decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'h00;
    end else if (w_hold_first && w_zip_bad && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'h00;
`endif

  assign current_state = r_cur_state;
  assign en            = r_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign zip_cap       = r_zip_cap;
  assign mismatch      = r_mismatch;

endmodule

// File: tb/tb_state_update_driver.sv
// ----------------------------------------------------------------------------
// tb_state_update_driver
//   Directed bench for state_update_driver with default timing parameters
//   (setup 1, pulse 2, hold 1). A behavioural level-sensitive latch returns
//   Zip to the DUT and can be told to return a wrong value for S1.
//   Honours STATE_UPDATE_ERRCNT_EN for the expected err_cnt.
// ----------------------------------------------------------------------------
module tb_state_update_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       step = 1'b0;
  logic [1:0] zip_in;
  logic [1:0] current_state;
  logic       en;
  logic       busy;
  logic       done;
  logic [1:0] zip_cap;
  logic       mismatch;
  logic [7:0] err_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic       fault_s1 = 1'b0;
  logic [1:0] latch_q  = 2'b00;

`ifdef STATE_UPDATE_ERRCNT_EN
  localparam logic [7:0] EXP_ERR_AFTER_FAULT = 8'd1;
`else
  localparam logic [7:0] EXP_ERR_AFTER_FAULT = 8'd0;
`endif

  state_update_driver dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .step          (step),
    .zip_in        (zip_in),
    .current_state (current_state),
    .en            (en),
    .busy          (busy),
    .done          (done),
    .zip_cap       (zip_cap),
    .mismatch      (mismatch),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model of the level-sensitive latch: transparent while en=1.
  always @(*) begin
    if (en) begin
      if (current_state == 2'b01) latch_q = fault_s1 ? 2'b01 : 2'b11;
      else                        latch_q = 2'b00;
    end
  end
  assign zip_in = latch_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    go    = 1'b0;
    step  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one step and wait (bounded) for done, then check the capture.
  task automatic run_step(input string tag, input logic [1:0] exp_cs,
                          input logic [1:0] exp_zip, input logic exp_mm,
                          input logic [7:0] exp_err);
    int n;
    step = 1'b1;
    tick();
    step = 1'b0;
    check({tag, " cs"}, 32'(current_state), 32'(exp_cs));
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " zip_cap"}, 32'(zip_cap), 32'(exp_zip));
    check({tag, " mismatch"}, 32'(mismatch), 32'(exp_mm));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
    tick();
  endtask

  initial begin
    logic [7:0] en_v;
    logic [7:0] done_v;
    logic [1:0] exp_cs_seq [5];
    logic [1:0] exp_zip_seq [5];
    int         busy_err;
    int         n_done;
    logic       done_seen;

    exp_cs_seq  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    exp_zip_seq = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00};

    // Reset held: toggling go/step must leave every output at zero.
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      go   = i[0];
      step = i[1];
      tick();
      check("reset outs", {20'd0, current_state, en, busy, done, zip_cap, mismatch, err_cnt}, 32'd0);
    end
    go   = 1'b0;
    step = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single step: en on cycles 2-3, done on cycle 5.
    en_v   = '0;
    done_v = '0;
    step = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      step = 1'b0;
      if (c == 1) begin
        check("step cs", 32'(current_state), 32'd0);
        check("step busy", 32'(busy), 32'd1);
      end
      en_v[c]   = en;
      done_v[c] = done;
    end
    check("step en timing", 32'(en_v), 32'h0C);
    check("step done timing", 32'(done_v), 32'h20);
    check("step zip_cap", 32'(zip_cap), 32'd0);
    check("step mismatch", 32'(mismatch), 32'd0);

    // go held for five back-to-back updates with wrap, then released.
    do_reset();
    busy_err = 0;
    go = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 18) go = 1'b0;
      if (busy !== (c <= 20)) busy_err++;
      if (c >= 2 && c <= 18 && ((c - 2) % 4) == 0) begin
        check("go cs", 32'(current_state), 32'(exp_cs_seq[(c - 2) / 4]));
        check("go en", 32'(en), 32'd1);
      end
      if (c >= 5 && c <= 21 && ((c - 5) % 4) == 0) begin
        check("go done", 32'(done), 32'd1);
        check("go zip_cap", 32'(zip_cap), 32'(exp_zip_seq[(c - 5) / 4]));
        check("go mismatch", 32'(mismatch), 32'd0);
      end
    end
    check("go busy gapless", 32'(busy_err), 32'd0);
    check("go final done", 32'(done), 32'd0);

    // Latch returns 01 for S1: mismatch flagged, then cleared by S2.
    do_reset();
    run_step("flt s0", 2'b00, 2'b00, 1'b0, 8'd0);
    fault_s1 = 1'b1;
    run_step("flt s1", 2'b01, 2'b01, 1'b1, EXP_ERR_AFTER_FAULT);
    fault_s1 = 1'b0;
    run_step("flt s2", 2'b10, 2'b00, 1'b0, EXP_ERR_AFTER_FAULT);

    // Reset asserted during PULSE: en drops at once, no done, restart at S0.
    do_reset();
    run_step("rst pre", 2'b00, 2'b00, 1'b0, 8'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("rst cs before", 32'(current_state), 32'd1);
    tick();
    check("rst en pulse", 32'(en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst en async", 32'(en), 32'd0);
    check("rst busy async", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      done_seen |= done;
    end
    check("rst no done", 32'(done_seen), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("rst restart cs", 32'(current_state), 32'd0);
    for (int c = 0; c < 6; c++) tick();

    // step while busy is dropped: one done, index advances by one.
    do_reset();
    n_done = 0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) n_done++;
    end
    check("busy step dones", 32'(n_done), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("busy step next cs", 32'(current_state), 32'd1);
    for (int c = 0; c < 6; c++) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
